res_writeback: RTL and testbench
================================

RES_WRITEBACK -- requirements
Module: res_writeback

Interface
REQ-001 SHALL have parameter N, default 4, number of PE results per batch.
REQ-002 SHALL have parameter DATA_W, default 32, result word width.
REQ-003 SHALL have parameter ADDR_W, default 32, result-memory address width.
REQ-004 SHALL have parameter BASE_ADDR, default 0, first result-memory address after reset or flush.
REQ-005 SHALL have parameter DEPTH, default 4, batch FIFO depth; power of two, at least 2.
REQ-006 SHALL have port clk  input  1  sole clock, rising edge.
REQ-007 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-008 SHALL have port resValidIn  input  1  batch of N PE results present.
REQ-009 SHALL have port resDataIn  input  N*DATA_W  packed results; PE i at bits [i*DATA_W +: DATA_W].
REQ-010 SHALL have port resReadyOut  output  1  batch FIFO can accept.
REQ-011 SHALL have port memWrEnOut  output  1  result-memory write request.
REQ-012 SHALL have port memAddrOut  output  ADDR_W  write address.
REQ-013 SHALL have port memDataOut  output  DATA_W  write data.
REQ-014 SHALL have port memReadyIn  input  1  memory accepts the write this cycle.
REQ-015 SHALL have port flushIn  input  1  restart addressing at BASE_ADDR for a new image.
REQ-016 SHALL have port idleOut  output  1  FIFO empty and FSM in IDLE.
REQ-017 SHALL have port wrCountOut  output  ADDR_W  words written since reset or flush.

Function
REQ-018 SHALL accept a batch on a rising edge where resValidIn and resReadyOut are both 1.
REQ-019 SHALL drive resReadyOut = (count < DEPTH), from registered count only; no pass-through at full, even with a same-cycle pop.
REQ-020 SHALL run a two-state FSM: IDLE, WRITE.
REQ-021 SHALL move IDLE->WRITE on the edge after count becomes nonzero; the first memWrEnOut comes one cycle after batch acceptance.
REQ-022 SHALL in WRITE drive memWrEnOut=1, memDataOut = head batch word idx, memAddrOut = address counter.
REQ-023 SHALL on memReadyIn=1 in WRITE increment idx and the address counter, and increment wrCountOut.
REQ-024 SHALL hold idx, address and data stable while memReadyIn=0.
REQ-025 SHALL on the write of idx = N-1 with memReadyIn=1 pop the FIFO and clear idx to 0; it SHALL stay in WRITE if any batch remains, counting a same-cycle push, else go to IDLE.
REQ-026 SHALL write the words of a batch in PE order 0..N-1, and batches in arrival order.
REQ-027 SHALL wrap the address counter and wrCountOut modulo 2^ADDR_W.
REQ-028 SHALL honour flushIn only when idleOut=1: the address counter goes to BASE_ADDR and wrCountOut to 0 on the next edge; flushIn SHALL be ignored otherwise.
REQ-029 SHALL drive memWrEnOut=0 in IDLE; memAddrOut and memDataOut are don't-care then.

Reset
REQ-030 SHALL on rst=1 at a rising edge empty the FIFO, set FSM to IDLE, idx to 0, address counter to BASE_ADDR and wrCountOut to 0; rst SHALL take priority over all inputs.
REQ-031 SHALL output after reset resReadyOut=1, memWrEnOut=0, idleOut=1, wrCountOut=0, memAddrOut=BASE_ADDR, memDataOut=0.
REQ-032 SHALL drop in-flight batches on reset mid-write, with no further writes.

Configuration
REQ-033 SHALL, with macro RES_RELU_EN defined, drive memDataOut as 0 for any word whose signed MSB is 1, applied combinationally at the output.
REQ-034 SHALL, without RES_RELU_EN, pass words unmodified.

Structure
REQ-035 SHALL put the FSM state enum and default parameter constants in shared package res_wb_pkg.
REQ-036 SHALL implement the batch storage as sub-module res_fifo (DEPTH x N*DATA_W, registered count, push/pop).

Verification
REQ-037 Single batch {5,6,7,8}, memReadyIn=1 -> writes at addr 0,1,2,3 in four consecutive cycles, starting one cycle after acceptance; then idleOut=1 and wrCountOut=4.
REQ-038 Five back-to-back batches, memReadyIn=0 -> resReadyOut drops after 4 accepts; the fifth is held; no loss once memReadyIn=1; 20 writes at addr 0..19.
REQ-039 memReadyIn toggled 1,0,0,1 mid-batch -> memAddrOut and memDataOut held during the 0 cycles; no duplicate or skipped word.
REQ-040 flushIn pulsed during WRITE -> ignored; flushIn pulsed when idle -> next batch writes from BASE_ADDR and wrCountOut restarts at 0.
REQ-041 rst asserted on the 2nd word of a batch -> memWrEnOut=0 next cycle; resReadyOut=1; next batch writes at BASE_ADDR.
REQ-042 Word 0x8000_0003 -> written as 0 with RES_RELU_EN, as 0x8000_0003 without it.

Source files
------------

// File: rtl/res_wb_pkg.sv
// rtl/res_wb_pkg.sv - shared state enum, default parameters and helpers for the result writeback block
package res_wb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_WRITE = 1'b1
  } wb_state_e;

  localparam int unsigned DEF_N      = 4;
  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned DEF_DEPTH  = 4;

  // Index width that stays legal when N is 1.
  function automatic int unsigned clog2_min1(input int unsigned v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/res_fifo.sv
// rtl/res_fifo.sv - power-of-two batch FIFO with registered count; head word visible without a read strobe
module res_fifo
  import res_wb_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned W     = DEF_N * DEF_DATA_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [W-1:0]             data_i,
  output logic [W-1:0]             data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/res_writeback.sv
// rtl/res_writeback.sv - streams N-word PE result batches to result memory; RES_RELU_EN zeroes negative words
module res_writeback
  import res_wb_pkg::*;
#(
  parameter int unsigned       N         = DEF_N,
  parameter int unsigned       DATA_W    = DEF_DATA_W,
  parameter int unsigned       ADDR_W    = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int unsigned       DEPTH     = DEF_DEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                resValidIn,
  input  logic [N*DATA_W-1:0] resDataIn,
  output logic                resReadyOut,
  output logic                memWrEnOut,
  output logic [ADDR_W-1:0]   memAddrOut,
  output logic [DATA_W-1:0]   memDataOut,
  input  logic                memReadyIn,
  input  logic                flushIn,
  output logic                idleOut,
  output logic [ADDR_W-1:0]   wrCountOut
);

  localparam int unsigned IW = clog2_min1(N);
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  wb_state_e           state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   wrcnt_q, wrcnt_d;
  logic [N*DATA_W-1:0] head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  logic                push, pop, wr_accept, last_word;
  logic [DATA_W-1:0]   word, out_word;

  res_fifo #(
    .DEPTH (DEPTH),
    .W     (N * DATA_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (resDataIn),
    .data_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Ready comes from the registered count only, so a full FIFO never passes a batch through.
  assign resReadyOut = !fifo_full;
  assign push        = resValidIn && resReadyOut;
  assign wr_accept   = (state_q == ST_WRITE) && memReadyIn;
  assign last_word   = (idx_q == IDX_LAST);
  assign pop         = wr_accept && last_word;
  assign idleOut     = (state_q == ST_IDLE) && fifo_empty;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    addr_d  = addr_q;
    wrcnt_d = wrcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) state_d = ST_WRITE;
        if (idleOut && flushIn) begin
          addr_d  = BASE_ADDR;
          wrcnt_d = '0;
        end
      end
      ST_WRITE: begin
        if (wr_accept) begin
          addr_d  = addr_q + ADDR_W'(1);
          wrcnt_d = wrcnt_q + ADDR_W'(1);
          idx_d   = last_word ? '0 : idx_q + IW'(1);
          // Leaving on the last word needs this to be the only batch, with nothing arriving now.
          if (last_word && fifo_count == CW'(1) && !push) state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      addr_q  <= BASE_ADDR;
      wrcnt_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      wrcnt_q <= wrcnt_d;
    end
  end

  assign word = head[idx_q*DATA_W +: DATA_W];

  always_comb begin
    out_word = word;
`ifdef RES_RELU_EN
    if (word[DATA_W-1]) out_word = '0;
`else
    out_word = word;
`endif
  end

  assign memWrEnOut = (state_q == ST_WRITE);
  assign memAddrOut = addr_q;
  assign memDataOut = memWrEnOut ? out_word : '0;
  assign wrCountOut = wrcnt_q;

endmodule

// File: tb/tb_res_writeback.sv
// tb/tb_res_writeback.sv - scoreboard bench for res_writeback
module tb_res_writeback;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;
  localparam logic [AW-1:0] BASE = '0;

  logic            clk = 1'b0;
  logic            rst, resValidIn, resReadyOut, memWrEnOut, memReadyIn, flushIn, idleOut;
  logic [N*DW-1:0] resDataIn;
  logic [AW-1:0]   memAddrOut, wrCountOut;
  logic [DW-1:0]   memDataOut;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb_q[$];
  wr_t           mon_e;
  logic [AW-1:0] exp_addr, exp_cnt;

  always #5 clk = ~clk;

  res_writeback #(
    .N(N), .DATA_W(DW), .ADDR_W(AW), .BASE_ADDR(BASE), .DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .resValidIn(resValidIn), .resDataIn(resDataIn),
    .resReadyOut(resReadyOut), .memWrEnOut(memWrEnOut), .memAddrOut(memAddrOut),
    .memDataOut(memDataOut), .memReadyIn(memReadyIn), .flushIn(flushIn),
    .idleOut(idleOut), .wrCountOut(wrCountOut)
  );

  function automatic logic [DW-1:0] model_word(input logic [DW-1:0] w);
`ifdef RES_RELU_EN
    return w[DW-1] ? '0 : w;
`else
    return w;
`endif
  endfunction

  function automatic logic [N*DW-1:0] mk(input logic [DW-1:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  always @(negedge clk) begin
    if (!rst && memWrEnOut && memReadyIn) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write addr=%h data=%h", memAddrOut, memDataOut);
      end else begin
        mon_e = sb_q.pop_front();
        if (memAddrOut !== mon_e.addr || memDataOut !== mon_e.data) begin
          errors++;
          $display("FAIL sb_write got addr=%h data=%h want addr=%h data=%h",
                   memAddrOut, memDataOut, mon_e.addr, mon_e.data);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b1; resValidIn = 1'b0; memReadyIn = 1'b0; flushIn = 1'b0; resDataIn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb_q.delete();
    exp_addr = BASE;
    exp_cnt  = '0;
  endtask

  task automatic push_batch(input logic [N*DW-1:0] d);
    int t = 0;
    resDataIn  = d;
    resValidIn = 1'b1;
    while (!resReadyOut && t < 200) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 200) begin
      checks++; errors++;
      $display("FAIL push_timeout ready=%b want 1", resReadyOut);
    end else begin
      @(posedge clk);
      for (int i = 0; i < N; i++) begin
        sb_q.push_back({exp_addr, model_word(d[i*DW +: DW])});
        exp_addr++;
        exp_cnt++;
      end
      #1;
    end
    resValidIn = 1'b0;
  endtask

  task automatic wait_idle;
    int t = 0;
    while (!idleOut && t < 500) begin
      @(negedge clk); t++;
    end
    checks++;
    if (!idleOut || sb_q.size() != 0) begin
      errors++;
      $display("FAIL idle_drain idle=%b pending=%0d want idle=1 pending=0", idleOut, sb_q.size());
    end
  endtask

  task automatic wait_wr;
    int t = 0;
    while (!memWrEnOut && t < 50) begin
      @(posedge clk); #1; t++;
    end
    checks++;
    if (!memWrEnOut) begin
      errors++;
      $display("FAIL wr_start_timeout wren=%b want 1", memWrEnOut);
    end
  endtask

  task automatic pulse_flush;
    flushIn = 1'b1;
    @(posedge clk); #1;
    flushIn = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++;
    if (resReadyOut !== 1'b1 || memWrEnOut !== 1'b0 || idleOut !== 1'b1 ||
        wrCountOut !== '0 || memAddrOut !== BASE || memDataOut !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%b wren=%b idle=%b cnt=%h addr=%h data=%h want 1 0 1 0 %h 0",
               resReadyOut, memWrEnOut, idleOut, wrCountOut, memAddrOut, memDataOut, BASE);
    end
  endtask

  task automatic test_single;
    memReadyIn = 1'b1;
    push_batch(mk(32'd5, 32'd6, 32'd7, 32'd8));
    @(negedge clk);
    checks++;
    if (memWrEnOut !== 1'b0) begin
      errors++;
      $display("FAIL single_latency_early wren=%b want 0", memWrEnOut);
    end
    @(negedge clk);
    checks++;
    if (memWrEnOut !== 1'b1 || memAddrOut !== BASE) begin
      errors++;
      $display("FAIL single_first_write wren=%b addr=%h want 1 %h", memWrEnOut, memAddrOut, BASE);
    end
    for (int i = 1; i < N; i++) begin
      @(negedge clk);
      checks++;
      if (memWrEnOut !== 1'b1) begin
        errors++;
        $display("FAIL single_consecutive word=%0d wren=%b want 1", i, memWrEnOut);
      end
    end
    wait_idle();
    checks++;
    if (wrCountOut !== 32'd4) begin
      errors++;
      $display("FAIL single_wrcount got %0d want 4", wrCountOut);
    end
  endtask

  task automatic test_back_to_back;
    memReadyIn = 1'b0;
    pulse_flush();
    exp_addr = BASE;
    exp_cnt  = '0;
    for (int k = 0; k < DEPTH; k++)
      push_batch(mk(32'(k*16+0), 32'(k*16+1), 32'(k*16+2), 32'(k*16+3)));
    resDataIn  = mk(32'h40, 32'h41, 32'h42, 32'h43);
    resValidIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (resReadyOut !== 1'b0) begin
        errors++;
        $display("FAIL b2b_full_ready cycle=%0d got %b want 0", c, resReadyOut);
      end
      @(posedge clk); #1;
    end
    memReadyIn = 1'b1;
    push_batch(mk(32'h40, 32'h41, 32'h42, 32'h43));
    wait_idle();
    checks++;
    if (wrCountOut !== 32'd20 || memAddrOut !== BASE + 32'd20) begin
      errors++;
      $display("FAIL b2b_totals cnt=%0d addr=%h want 20 %h", wrCountOut, memAddrOut, BASE + 32'd20);
    end
  endtask

  task automatic test_stall;
    logic          pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    logic [AW-1:0] a;
    logic [DW-1:0] dt;
    memReadyIn = 1'b0;
    push_batch(mk(32'h11, 32'h22, 32'h33, 32'h44));
    wait_wr();
    for (int p = 0; p < 6; p++) begin
      memReadyIn = pat[p];
      a  = memAddrOut;
      dt = memDataOut;
      @(posedge clk); #1;
      if (!pat[p]) begin
        checks++;
        if (memAddrOut !== a || memDataOut !== dt) begin
          errors++;
          $display("FAIL stall_hold step=%0d addr=%h data=%h want %h %h", p, memAddrOut, memDataOut, a, dt);
        end
      end
    end
    memReadyIn = 1'b1;
    wait_idle();
  endtask

  task automatic test_flush;
    memReadyIn = 1'b1;
    push_batch(mk(32'h1, 32'h2, 32'h3, 32'h4));
    wait_wr();
    pulse_flush();
    wait_idle();
    checks++;
    if (wrCountOut !== exp_cnt) begin
      errors++;
      $display("FAIL flush_ignored cnt=%0d want %0d", wrCountOut, exp_cnt);
    end
    pulse_flush();
    exp_addr = BASE;
    exp_cnt  = '0;
    checks++;
    if (wrCountOut !== '0 || memAddrOut !== BASE) begin
      errors++;
      $display("FAIL flush_idle cnt=%0d addr=%h want 0 %h", wrCountOut, memAddrOut, BASE);
    end
    push_batch(mk(32'h9, 32'ha, 32'hb, 32'hc));
    wait_idle();
    checks++;
    if (wrCountOut !== 32'd4) begin
      errors++;
      $display("FAIL flush_recount cnt=%0d want 4", wrCountOut);
    end
  endtask

  task automatic test_reset_mid;
    memReadyIn = 1'b1;
    push_batch(mk(32'h21, 32'h22, 32'h23, 32'h24));
    wait_wr();
    @(posedge clk); #1;
    rst = 1'b1;
    memReadyIn = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    sb_q.delete();
    exp_addr = BASE;
    exp_cnt  = '0;
    checks++;
    if (memWrEnOut !== 1'b0 || resReadyOut !== 1'b1 || idleOut !== 1'b1 || wrCountOut !== '0) begin
      errors++;
      $display("FAIL reset_mid wren=%b rdy=%b idle=%b cnt=%0d want 0 1 1 0",
               memWrEnOut, resReadyOut, idleOut, wrCountOut);
    end
    memReadyIn = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++;
      if (memWrEnOut !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_quiet cycle=%0d wren=%b want 0", c, memWrEnOut);
      end
    end
    @(posedge clk); #1;
    push_batch(mk(32'h31, 32'h32, 32'h33, 32'h34));
    wait_idle();
  endtask

  task automatic test_relu;
    logic [DW-1:0] want;
`ifdef RES_RELU_EN
    want = '0;
`else
    want = 32'h8000_0003;
`endif
    memReadyIn = 1'b1;
    push_batch(mk(32'h8000_0003, 32'h1, 32'hffff_ffff, 32'h7fff_ffff));
    wait_wr();
    checks++;
    if (memDataOut !== want) begin
      errors++;
      $display("FAIL relu_word got %h want %h", memDataOut, want);
    end
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    test_relu();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
